// File: rtl/game_over_font_pkg.sv
// game_over_font_pkg
// Shared constants for the game-over text responder:
//   - character codes (ASCII values) for every letter the two messages use
//   - the two 9-column messages, column 0 in the most significant byte
//   - the 8x8 glyph table, glyph row 0 in the most significant byte
//   - default scale / glyph size constants
//   - helpers: message lookup, glyph row lookup, line-to-glyph-row divider
package game_over_font_pkg;

  localparam int DEFAULT_SCALE = 10;
  localparam int GLYPH_PX      = 8;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_G     = 8'h47;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_Y     = 8'h59;

  // Column 0 sits in bits [71:64].
  localparam logic [71:0] MSG_GAME_OVER =
    {CH_G, CH_A, CH_M, CH_E, CH_SPACE, CH_O, CH_V, CH_E, CH_R};
  localparam logic [71:0] MSG_VICTORY =
    {CH_SPACE, CH_V, CH_I, CH_C, CH_T, CH_O, CH_R, CH_Y, CH_SPACE};

  // Glyph row 0 sits in bits [63:56]; bit 7 of each row is the leftmost pixel.
  localparam logic [63:0] GLYPH_A = 64'h1824_4242_7E42_4200;
  localparam logic [63:0] GLYPH_C = 64'h3C42_4040_4042_3C00;
  localparam logic [63:0] GLYPH_E = 64'h7E40_407C_4040_7E00;
  localparam logic [63:0] GLYPH_G = 64'h3C42_404E_4242_3C00;
  localparam logic [63:0] GLYPH_I = 64'h3C18_1818_1818_3C00;
  localparam logic [63:0] GLYPH_M = 64'h4266_5A42_4242_4200;
  localparam logic [63:0] GLYPH_O = 64'h3C42_4242_4242_3C00;
  localparam logic [63:0] GLYPH_R = 64'h7C42_427C_4844_4200;
  localparam logic [63:0] GLYPH_T = 64'h7E18_1818_1818_1800;
  localparam logic [63:0] GLYPH_V = 64'h4242_4242_4224_1800;
  localparam logic [63:0] GLYPH_Y = 64'h4242_2418_1818_1800;

  // Character code at message column col (caller guarantees col < 9).
  function automatic logic [7:0] msg_char(input logic sel, input logic [3:0] col);
    logic [71:0] msg;
    logic [71:0] shifted;
    msg     = sel ? MSG_VICTORY : MSG_GAME_OVER;
    shifted = msg << {col, 3'b000};
    return shifted[71:64];
  endfunction

  // One 8-pixel row of a glyph; SPACE and unknown codes are blank.
  function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [2:0] row);
    logic [63:0] glyph;
    logic [63:0] shifted;
    case (code)
      CH_A:    glyph = GLYPH_A;
      CH_C:    glyph = GLYPH_C;
      CH_E:    glyph = GLYPH_E;
      CH_G:    glyph = GLYPH_G;
      CH_I:    glyph = GLYPH_I;
      CH_M:    glyph = GLYPH_M;
      CH_O:    glyph = GLYPH_O;
      CH_R:    glyph = GLYPH_R;
      CH_T:    glyph = GLYPH_T;
      CH_V:    glyph = GLYPH_V;
      CH_Y:    glyph = GLYPH_Y;
      default: glyph = 64'h0;
    endcase
    shifted = glyph << {row, 3'b000};
    return shifted[63:56];
  endfunction

  // Constant-divisor division of the pixel line by scale, built as a
  // comparator chain against the fixed multiples of scale. Result is
  // {blank, glyph_row}; blank is set once the line leaves the cell.
  function automatic logic [3:0] line_to_row(input logic [7:0] line, input int scale);
    logic [3:0] res;
    res = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      res = (int'(line) < (k + 1) * scale) ? 4'(k) : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/font_rom_8x8.sv
// font_rom_8x8
// Registered 8x8 font lookup (second pipeline stage of the responder).
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset, clears the row register
//   blank : forces the registered row to zero (used for blinking)
//   code  : character code
//   row   : glyph row 0..7
//   glyph : registered 8-bit glyph row, bit 7 = leftmost pixel
module font_rom_8x8
  import game_over_font_pkg::*;
(
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       blank,
  input  logic [7:0] code,
  input  logic [2:0] row,
  output logic [7:0] glyph
);

  logic [7:0] glyph_r;

  // Glyph row register; blanking takes effect in the same stage so latency is unchanged.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_r <= 8'h00;
    end else if (blank) begin
      glyph_r <= 8'h00;
    end else begin
      glyph_r <= glyph_row(code, row);
    end
  end

  assign glyph = glyph_r;

endmodule

// File: rtl/game_over_char_rom.sv
// game_over_char_rom
// Answers the game-over overlay's character request with a scaled line bitmap
// exactly two pclk cycles after the request.
//   pclk                  : pixel clock
//   rst_n                 : asynchronous active-low reset
//   vsync_in              : vertical sync; rising edge = frame boundary
//   victory               : selects " VICTORY " instead of "GAME OVER"
//   char_yx_game_over     : [7:4] character row, [3:0] character column
//   char_line_game_over   : pixel line within the cell, 0..8*SCALE-1
//   char_pixels_game_over : line bitmap, bit 8*SCALE-1 = leftmost pixel
// Build option: define GAME_OVER_BLINK_EN to blank the text for 32 of
// every 64 frames.
module game_over_char_rom
  import game_over_font_pkg::*;
#(
  parameter int SCALE   = DEFAULT_SCALE,
  parameter int MSG_LEN = 9
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        vsync_in,
  input  logic                        victory,
  input  logic [7:0]                  char_yx_game_over,
  input  logic [7:0]                  char_line_game_over,
  output logic [GLYPH_PX*SCALE-1:0]   char_pixels_game_over
);

  logic       vsync_d_r;
  logic       msg_sel_r;
  logic       vsync_rise_s;
  logic [7:0] code_s;
  logic [2:0] row_s;
  logic [3:0] line_row_s;
  logic [7:0] code_r;
  logic [2:0] row_r;
  logic       blank_s;
  logic [7:0] glyph_s;

  assign vsync_rise_s = vsync_in & ~vsync_d_r;

  // Frame-boundary detect and once-per-frame message latch.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
      msg_sel_r <= 1'b0;
    end else begin
      vsync_d_r <= vsync_in;
      msg_sel_r <= vsync_rise_s ? victory : msg_sel_r;
    end
  end

  // Stage 1 lookup: anything outside row 0, past the message, or below the
  // cell becomes SPACE so stage 2 produces an empty line.
  always_comb begin
    code_s     = CH_SPACE;
    row_s      = 3'd0;
    line_row_s = line_to_row(char_line_game_over, SCALE);
    if ((char_yx_game_over[7:4] == 4'd0) &&
        (int'(char_yx_game_over[3:0]) < MSG_LEN) &&
        !line_row_s[3]) begin
      code_s = msg_char(msg_sel_r, char_yx_game_over[3:0]);
      row_s  = line_row_s[2:0];
    end else begin
      code_s = CH_SPACE;
      row_s  = 3'd0;
    end
  end

  // Stage 1 register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      code_r <= 8'h00;
      row_r  <= 3'd0;
    end else begin
      code_r <= code_s;
      row_r  <= row_s;
    end
  end

`ifdef GAME_OVER_BLINK_EN
  logic [5:0] blink_cnt_r;

  // Frame counter; its MSB hides the text for half of each 64-frame period.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= 6'd0;
    end else if (vsync_rise_s) begin
      blink_cnt_r <= blink_cnt_r + 6'd1;
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  assign blank_s = blink_cnt_r[5];
`else
  assign blank_s = 1'b0;
`endif

  font_rom_8x8 u_font_rom (
    .pclk  (pclk),
    .rst_n (rst_n),
    .blank (blank_s),
    .code  (code_r),
    .row   (row_r),
    .glyph (glyph_s)
  );

  // Expansion is pure fan-out of the stage 2 register: glyph bit 7-k drives
  // output slice [8*SCALE-1-k*SCALE -: SCALE].
  for (genvar k = 0; k < GLYPH_PX; k++) begin : g_expand
    assign char_pixels_game_over[GLYPH_PX*SCALE-1-k*SCALE -: SCALE] = {SCALE{glyph_s[GLYPH_PX-1-k]}};
  end

endmodule

// File: tb/tb_game_over_char_rom.sv
module tb_game_over_char_rom;

  logic        pclk;
  logic        rst_n;
  logic        vsync_in;
  logic        victory;
  logic [7:0]  char_yx_game_over;
  logic [7:0]  char_line_game_over;
  logic [79:0] char_pixels_game_over;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [7:0] yx;
    logic [7:0] ln;
    logic       vs;
    logic       vic;
    logic [7:0] row;
    string      nm;
  } vec_t;

  vec_t        vecs[$];
  logic [79:0] exp_q[$];
  string       nm_q[$];

  game_over_char_rom dut (
    .pclk                  (pclk),
    .rst_n                 (rst_n),
    .vsync_in              (vsync_in),
    .victory               (victory),
    .char_yx_game_over     (char_yx_game_over),
    .char_line_game_over   (char_line_game_over),
    .char_pixels_game_over (char_pixels_game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Replicate each glyph bit ten times, leftmost pixel first.
  function automatic logic [79:0] expand(input logic [7:0] row);
    logic [79:0] e;
    logic [7:0]  r;
    e = 80'h0;
    r = row;
    for (int k = 0; k < 8; k++) begin
      e = (e << 10) | (r[7] ? 80'h3FF : 80'h0);
      r = r << 1;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] yx, input logic [7:0] ln, input logic vs,
                               input logic vic, input logic [7:0] row, input string nm);
    vec_t v;
    v.yx = yx; v.ln = ln; v.vs = vs; v.vic = vic; v.row = row; v.nm = nm;
    return v;
  endfunction

  task automatic check(input logic [79:0] got, input logic [79:0] exp, input string nm);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One request per cycle; the output seen after this edge belongs to the
  // request driven one cycle earlier (two edges in total).
  task automatic drive(input logic [7:0] yx, input logic [7:0] ln, input logic vs,
                       input logic vic, input logic [7:0] row, input string nm);
    logic [79:0] e;
    string       n;
    @(negedge pclk);
    char_yx_game_over   = yx;
    char_line_game_over = ln;
    vsync_in            = vs;
    victory             = vic;
    exp_q.push_back(expand(row));
    nm_q.push_back(nm);
    @(posedge pclk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(char_pixels_game_over, e, n);
    end
  endtask

  // Release reset with an idle request on the bus and check the first output.
  task automatic release_reset(input string nm);
    @(negedge pclk);
    char_yx_game_over   = 8'h0F;
    char_line_game_over = 8'd0;
    vsync_in            = 1'b0;
    rst_n               = 1'b1;
    exp_q.delete();
    nm_q.delete();
    exp_q.push_back(80'h0);
    nm_q.push_back({nm, "_cycle1"});
    @(posedge pclk);
    #1;
    check(char_pixels_game_over, 80'h0, {nm, "_cycle0"});
  endtask

  logic [7:0] go_r0 [9];
  logic [7:0] go_r1 [9];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    vsync_in = 1'b0;
    victory = 1'b0;
    char_yx_game_over = 8'h00;
    char_line_game_over = 8'd0;

    go_r0 = '{8'h3C, 8'h18, 8'h42, 8'h7E, 8'h00, 8'h3C, 8'h42, 8'h7E, 8'h7C};
    go_r1 = '{8'h42, 8'h24, 8'h66, 8'h40, 8'h00, 8'h42, 8'h42, 8'h40, 8'h42};

    vecs.push_back(mkv(8'h00, 8'd0,   1'b0, 1'b0, 8'h3C, "G_r0"));
    vecs.push_back(mkv(8'h01, 8'd0,   1'b0, 1'b0, 8'h18, "A_r0"));
    vecs.push_back(mkv(8'h02, 8'd9,   1'b0, 1'b0, 8'h42, "M_r0_l9"));
    vecs.push_back(mkv(8'h02, 8'd10,  1'b0, 1'b0, 8'h66, "M_r1_l10"));
    vecs.push_back(mkv(8'h05, 8'd69,  1'b0, 1'b0, 8'h3C, "O_r6"));
    vecs.push_back(mkv(8'h08, 8'd79,  1'b0, 1'b0, 8'h00, "R_r7_l79"));
    vecs.push_back(mkv(8'h08, 8'd55,  1'b0, 1'b0, 8'h44, "R_r5"));
    vecs.push_back(mkv(8'h04, 8'd30,  1'b0, 1'b0, 8'h00, "space_col4"));
    vecs.push_back(mkv(8'h09, 8'd0,   1'b0, 1'b0, 8'h00, "col9"));
    vecs.push_back(mkv(8'h0F, 8'd0,   1'b0, 1'b0, 8'h00, "col15"));
    vecs.push_back(mkv(8'h10, 8'd0,   1'b0, 1'b0, 8'h00, "row1"));
    vecs.push_back(mkv(8'h00, 8'd80,  1'b0, 1'b0, 8'h00, "line80"));
    vecs.push_back(mkv(8'h00, 8'd255, 1'b0, 1'b0, 8'h00, "line255"));
    vecs.push_back(mkv(8'h06, 8'd55,  1'b0, 1'b0, 8'h24, "V_r5"));
    vecs.push_back(mkv(8'h00, 8'd0,   1'b0, 1'b1, 8'h3C, "vic_no_edge"));
    vecs.push_back(mkv(8'h00, 8'd0,   1'b1, 1'b1, 8'h3C, "edge_req_old_sel"));
    vecs.push_back(mkv(8'h01, 8'd35,  1'b1, 1'b0, 8'h42, "vic_V_r3"));
    vecs.push_back(mkv(8'h00, 8'd0,   1'b1, 1'b0, 8'h00, "vic_space"));
    vecs.push_back(mkv(8'h02, 8'd20,  1'b1, 1'b0, 8'h18, "vic_I_r2"));
    vecs.push_back(mkv(8'h08, 8'd0,   1'b1, 1'b0, 8'h00, "vic_col8_space"));
    vecs.push_back(mkv(8'h07, 8'd60,  1'b1, 1'b0, 8'h18, "vic_Y_r6"));
    vecs.push_back(mkv(8'h03, 8'd0,   1'b1, 1'b0, 8'h3C, "vic_C_r0"));
    vecs.push_back(mkv(8'h04, 8'd10,  1'b0, 1'b0, 8'h18, "vic_T_r1_midframe"));
    vecs.push_back(mkv(8'h01, 8'd0,   1'b1, 1'b0, 8'h42, "edge_vic0_old"));
    vecs.push_back(mkv(8'h01, 8'd0,   1'b1, 1'b1, 8'h18, "go_A_r0"));
    vecs.push_back(mkv(8'h0F, 8'd0,   1'b0, 1'b0, 8'h00, "idle"));

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check(char_pixels_game_over, 80'h0, "reset_out");
    release_reset("post_reset");

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].yx, vecs[i].ln, vecs[i].vs, vecs[i].vic, vecs[i].row, vecs[i].nm);
    end

    // Back-to-back columns across the line 9 -> 10 glyph-row step
    for (int c = 0; c < 9; c++) begin
      drive(8'(c), 8'd9, 1'b0, 1'b0, go_r0[c], $sformatf("b2b_l9_col%0d", c));
    end
    for (int c = 0; c < 9; c++) begin
      drive(8'(c), 8'd10, 1'b0, 1'b0, go_r1[c], $sformatf("b2b_l10_col%0d", c));
    end

    // Switch to victory, then reset mid-stream
    drive(8'h0F, 8'd0, 1'b0, 1'b1, 8'h00, "pre_edge");
    drive(8'h0F, 8'd0, 1'b1, 1'b1, 8'h00, "edge_vic1");
    drive(8'h00, 8'd0, 1'b0, 1'b1, 8'h00, "vic2_space");
    drive(8'h01, 8'd0, 1'b0, 1'b1, 8'h42, "vic2_V_r0");
    drive(8'h02, 8'd0, 1'b0, 1'b1, 8'h3C, "vic2_I_r0");
    #2;
    rst_n = 1'b0;
    #1;
    check(char_pixels_game_over, 80'h0, "async_reset_out");
    release_reset("mid_reset");
    drive(8'h00, 8'd0, 1'b0, 1'b1, 8'h3C, "after_reset_G_r0");
    drive(8'h01, 8'd0, 1'b0, 1'b1, 8'h18, "after_reset_A_r0");
    drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "flush0");
    drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "flush1");

`ifdef GAME_OVER_BLINK_EN
    // Blink: letters hidden after 32 frame edges, back after 64
    @(negedge pclk);
    rst_n = 1'b0;
    release_reset("blink_reset");
    for (int f = 0; f < 32; f++) begin
      drive(8'h0F, 8'd0, 1'b1, 1'b0, 8'h00, "blink_vs_hi");
      drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "blink_vs_lo");
    end
    drive(8'h00, 8'd0, 1'b0, 1'b0, 8'h00, "blink_hidden_G");
    for (int f = 0; f < 32; f++) begin
      drive(8'h0F, 8'd0, 1'b1, 1'b0, 8'h00, "blink_vs_hi2");
      drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "blink_vs_lo2");
    end
    drive(8'h00, 8'd0, 1'b0, 1'b0, 8'h3C, "blink_shown_G");
    drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "blink_flush0");
    drive(8'h0F, 8'd0, 1'b0, 1'b0, 8'h00, "blink_flush1");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_over_char_rom.md
# game_over_char_rom

Font/text responder for the game-over overlay stage. It answers the overlay's character request (`char_yx_game_over`, `char_line_game_over`) with an 80-pixel line bitmap (`char_pixels_game_over`) exactly two `pclk` cycles later, matching the overlay's two-stage delay line. The message shown ("GAME OVER" or " VICTORY ") is latched once per frame, and each 8×8 font glyph is scaled ×10 into an 80×80 cell. It sits beside the overlay stage in the VGA pipeline and is driven from the same pixel clock.

## Interface
Parameters:
- `SCALE`, 10: pixel replication factor; the cell is `8*SCALE` = 80 pixels square.
- `MSG_LEN`, 9: number of character columns in the message row.

Ports:
- `pclk` input 1: pixel clock; the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `vsync_in` input 1: vertical sync from the timing chain; a rising edge marks the frame boundary.
- `victory` input 1: requests the victory message.
- `char_yx_game_over` input 8: request address; [7:4] is the character row, [3:0] is the character column.
- `char_line_game_over` input 8: pixel line within the cell, 0..79.
- `char_pixels_game_over` output 80: line bitmap; bit 79 is the leftmost pixel.

## Operation
- Message latch:
  - A 1-bit `msg_sel` register loads `victory` on each `vsync_in` rising edge, detected against a registered copy of `vsync_in`.
  - `msg_sel` is constant for the whole frame, so there is no mid-frame tearing.
  - 0 selects "GAME OVER"; 1 selects " VICTORY ".
- Stage 1, registered on the `pclk` edge after the request:
  - Text lookup: char code = `MSG[msg_sel][col]`.
  - The code is forced to SPACE when row ≠ 0 or col ≥ `MSG_LEN`.
  - Glyph row = `char_line_game_over / SCALE`, 3 bits.
  - The row is forced to blank (all-zero line) when `char_line_game_over` ≥ 80.
- Stage 2, registered:
  - The font ROM returns 8 bits; bit 7 is the leftmost pixel.
  - Expansion: output bits [79−10k : 70−10k] all equal glyph bit (7−k), for k = 0..7.
- SPACE and unknown codes produce an all-zero line.
- Division by 10 uses a constant-divisor implementation, synthesizable and combinational within stage 1. The quotient saturates to the blank row for inputs ≥ 80.

## Timing
- Latency: exactly 2 `pclk` cycles from request to `char_pixels_game_over`. Throughput is one request per cycle, with no stalls and no handshake.
- Reset values (asynchronous assert, on `rst_n` low):
  - `char_pixels_game_over` = 80'h0.
  - `msg_sel` = 0.
  - Stage registers = 0.
  - vsync history = 0.
  - Blink counter = 0.
- After `rst_n` deasserts, the first two outputs are zero; valid data follows from the third cycle.
- `vsync_in` edge and `victory` change in the same cycle: the value of `victory` sampled at that edge wins.
- Reset mid-frame: outputs go to zero immediately. The message returns to "GAME OVER" until the next vsync edge with `victory` = 1.
- Column wrap: col 9..15 always returns zero; there is no wrap into the message.

## Configuration
- `GAME_OVER_BLINK_EN` defined:
  - A 6-bit frame counter increments on each vsync rising edge and wraps 63→0.
  - While counter[5] = 1, stage 2 outputs all zeros; the letters vanish for 32 frames out of every 64.
  - Latency is unchanged.
- Undefined: no counter is built, and letters are always shown.

## Structure
- Package `game_over_font_pkg`:
  - Char code localparams: SPACE, A, C, E, G, I, M, O, R, T, V, Y.
  - The two 9-entry message arrays.
  - The 8×8 glyph table.
  - `SCALE` and the cell-size constants.
- Sub-module `font_rom_8x8`: inputs are char code and row (3 bits); output is 8 bits, registered (stage 2 storage).
- Top level contains the message latch, stage 1, the expansion logic and the optional blink counter.

## Test plan
- Reset, then request yx=8'h00, line=0 with no vsync edge: cycle+2 output = G glyph row 0 expanded; cycles 0–1 after reset = 0.
- `victory`=1, then a vsync rising edge; request yx=8'h01, line=35 (glyph row 3): cycle+2 output = V row 3, each bit replicated ×10. Request yx=8'h00: output = 0 (SPACE).
- Requests yx=8'h09, 8'h0F, 8'h10, and line=80 with yx=8'h00: all outputs 80'h0.
- Toggle `victory` mid-frame without a vsync edge: output unchanged until the next rising edge, after which the message switches.
- Back-to-back requests on consecutive cycles for col 0..8, line 9→10 crossing: each output appears in order at +2; the line 9→10 step changes the glyph row 0→1.
- With `GAME_OVER_BLINK_EN`: after 32 vsync edges, output = 0 for a visible letter; after 64 edges, the letter returns. Assert `rst_n` low mid-stream: output = 0 immediately.
